// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: IDLE -> REQ -> HOLD loop that drives next-PC and holds one fetched instruction.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pcNext,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    output logic        misalignTrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        retire_s;
    logic        bad_target_s;
    logic        bad_take_s;
    logic [31:0] target_s;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic        valid_r;

    // Retire decode and redirect-target qualification
    always_comb begin
        retire_s = (state_r == HOLD) && !stall;
`ifdef FETCH_MISALIGN_TRAP_EN
        bad_target_s = redirect && (redirectPc[1:0] != 2'b00);
        target_s     = redirectPc;
`else
        bad_target_s = 1'b0;
        target_s     = redirectPc & 32'hFFFF_FFFC;
`endif
        bad_take_s = retire_s && bad_target_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = REQ;
            REQ: begin
                if (imemAck) begin
                    state_s = HOLD;
                end else begin
                    state_s = REQ;
                end
            end
            HOLD: begin
                // A trapped redirect keeps the instruction parked in HOLD
                if (retire_s && !bad_take_s) begin
                    state_s = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next-PC selection for the external PC register
    always_comb begin
        pcNext = pc;
        if (rst) begin
            pcNext = RESET_PC;
        end else if (retire_s && redirect && !bad_target_s) begin
            pcNext = target_s;
        end else if (retire_s && !redirect) begin
            pcNext = pc + 32'd4;
        end else begin
            pcNext = pc;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Captured instruction, its address and the valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r    <= 32'h00000000;
            instr_pc_r <= 32'h00000000;
            valid_r    <= 1'b0;
        end else if ((state_r == REQ) && imemAck) begin
            instr_r    <= imemData;
            instr_pc_r <= pc;
            valid_r    <= 1'b1;
        end else if (retire_s && !bad_take_s) begin
            valid_r    <= 1'b0;
        end else begin
            valid_r    <= valid_r;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_r;

    // One-cycle pulse following a refused misaligned redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else begin
            trap_r <= bad_take_s;
        end
    end

    assign misalignTrap = trap_r;
`else
    assign misalignTrap = 1'b0;
`endif

    assign imemReq    = (state_r == REQ);
    assign imemAddr   = pc;
    assign instr      = instr_r;
    assign instrPc    = instr_pc_r;
    assign instrValid = valid_r;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios then random stimulus,
// compared every cycle against a behavioural model of the fetch loop.
module tb_fetch_seq;

    localparam logic [31:0] RST_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        misalignTrap;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: waiting-one-cycle flag, holding-an-instruction flag, trap pulse, PC
    bit          m_known = 1'b0;
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    bit          m_trap  = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_ipc   = 32'h0;

    fetch_seq #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pcNext(pcNext), .stall(stall),
        .redirect(redirect), .redirectPc(redirectPc), .imemReq(imemReq),
        .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instr(instr), .instrPc(instrPc), .instrValid(instrValid),
        .misalignTrap(misalignTrap)
    );

    always #5 clk = ~clk;

    // External PC register
    always @(posedge clk) pc <= pcNext;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), check, advance the model
    task automatic cyc(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic ack);
        bit          retire;
        bit          bad;
        logic [31:0] nxt;
        logic [31:0] data;
        data       = $urandom;
        rst        = r;
        stall      = s;
        redirect   = rd;
        redirectPc = rpc;
        imemAck    = ack;
        imemData   = data;
        #1;
        retire = m_known && !m_idle && m_valid && !s;
`ifdef FETCH_MISALIGN_TRAP_EN
        bad = rd && (rpc % 4 != 0);
`else
        bad = 1'b0;
`endif
        if (r)                    nxt = RST_PC;
        else if (!retire)         nxt = m_pc;
        else if (!rd)             nxt = m_pc + 32'd4;
        else if (bad)             nxt = m_pc;
        else                      nxt = (rpc / 4) * 4;
        chk("pcNext", pcNext, nxt);
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("imemReq", {31'd0, imemReq}, {31'd0, !m_idle && !m_valid});
            chk("instrValid", {31'd0, instrValid}, {31'd0, m_valid});
            chk("instr", instr, m_instr);
            chk("instrPc", instrPc, m_ipc);
            chk("misalignTrap", {31'd0, misalignTrap}, {31'd0, m_trap});
            if (!m_idle && !m_valid) chk("imemAddr", imemAddr, m_pc);
        end
        if (r) begin
            m_known = 1'b1; m_idle = 1'b1; m_valid = 1'b0; m_trap = 1'b0;
            m_instr = 32'h0; m_ipc = 32'h0;
        end else if (m_known) begin
            m_trap = retire && rd && bad;
            if (m_idle) begin
                m_idle = 1'b0;
            end else if (!m_valid) begin
                if (ack) begin
                    m_valid = 1'b1; m_instr = data; m_ipc = m_pc;
                end
            end else if (retire && !(rd && bad)) begin
                m_valid = 1'b0;
            end
        end
        m_pc = nxt;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset, then back-to-back fetches with same-cycle ack: 0x0, 0x4 ...
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);      // IDLE, ack ignored
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);      // REQ 0x0
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);      // retire
        // Ack delayed three cycles at 0x4
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);      // retire
        // Stall five cycles holding 0x8, then retire to 0xC
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (5) cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        // Redirect during REQ is ignored; redirect on retire goes to 0x100
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Misaligned redirect target
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Wrap: redirect to 0xFFFFFFFC, next sequential fetch is 0x0
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Reset while requesting 0x20 with an ack pending
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0) tgt = tgt & 32'hFFFF_FFFC;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, tgt, $urandom_range(0, 1) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
